// File: rtl/param_commit_pkg.sv
// param_commit_pkg: shared widths, FSM encoding and default parameter bank
package param_commit_pkg;
    localparam int PARAM_W = 32;
    localparam int ADDR_W = 8;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    // lce, gamma_dyn, gamma_sta, BDAMP_1, BDAMP_2, BDAMP_chain, clk_divider, spare (entry 0 in LSBs)
    localparam logic [8*PARAM_W-1:0] DEFAULT_RESET_VALS = {
        32'h0000_0000, 32'h0000_0000, 32'h3C58_44D0, 32'h3D14_4674,
        32'h3E71_4120, 32'h42A0_0000, 32'h42A0_0000, 32'h3F8C_CCCD
    };
endpackage

// File: rtl/param_commit_ctrl_if.sv
// param_commit_ctrl_if: host-side parameter write strobe bus
interface param_commit_ctrl_if;
    import param_commit_pkg::*;
    logic wr_stb;
    logic [ADDR_W-1:0] wr_addr;
    logic [PARAM_W-1:0] wr_data;
    modport master(output wr_stb, output wr_addr, output wr_data);
    modport slave(input wr_stb, input wr_addr, input wr_data);
endinterface

// File: rtl/param_fifo.sv
// param_fifo: synchronous write queue with full/empty/level status
module param_fifo
    import param_commit_pkg::*;
#(
    parameter int W = ADDR_W + PARAM_W,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  level
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0] level_q, level_d;
    logic do_push, do_pop;

    always_comb begin
        full = level_q == (AW+1)'(DEPTH);
        empty = level_q == '0;
        do_push = push && !full;
        do_pop = pop && !empty;
        mem_d = mem_q;
        if (do_push) mem_d[wptr_q] = wdata;
        wptr_d = wptr_q + AW'(do_push);
        rptr_d = rptr_q + AW'(do_pop);
        level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        rdata = mem_q[rptr_q];
        level = level_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            level_q <= '0;
        end else begin
            mem_q <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/param_commit_ctrl.sv
// param_commit_ctrl: queues host parameter writes and commits them atomically on sim_tick
module param_commit_ctrl
    import param_commit_pkg::*;
#(
    parameter int NPARAM = 8,
    parameter int FIFO_DEPTH = 4,
    parameter logic [NPARAM*PARAM_W-1:0] RESET_VALS = '0,
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    param_commit_ctrl_if.slave         wr,
    input  logic                       sim_tick,
    input  logic                       clr_err,
    output logic [NPARAM*PARAM_W-1:0]  params_out,
    output logic                       commit,
    output logic                       busy,
    output logic [LW-1:0]              fifo_level,
    output logic                       err_overflow,
    output logic                       err_badaddr,
    output logic                       err_tickmiss
);
    logic [ADDR_W+PARAM_W-1:0] rd_ent;
    logic [ADDR_W-1:0] rd_addr;
    logic [PARAM_W-1:0] rd_data;
    logic full, empty, pop, addr_ok;
    logic [1:0] state_q, state_d;
    logic [LW-1:0] n_drain_q, n_drain_d;
    logic [PARAM_W-1:0] shadow_q [NPARAM];
    logic [PARAM_W-1:0] shadow_d [NPARAM];
    logic [PARAM_W-1:0] live_q [NPARAM];
    logic [PARAM_W-1:0] live_d [NPARAM];
    logic commit_q, commit_d, ovf_q, ovf_d, bad_q, bad_d, miss_q, miss_d;

    param_fifo #(.W(ADDR_W + PARAM_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(wr.wr_stb),
        .pop(pop),
        .wdata({wr.wr_addr, wr.wr_data}),
        .rdata(rd_ent),
        .full(full),
        .empty(empty),
        .level(fifo_level)
    );

    always_comb begin
        rd_addr = rd_ent[PARAM_W +: ADDR_W];
        rd_data = rd_ent[PARAM_W-1:0];
        pop = (state_q == S_DRAIN) && !empty;
        addr_ok = {1'b0, rd_addr} < (ADDR_W+1)'(NPARAM);
        // occupancy is snapshotted at the tick so later pushes wait for the next tick
        state_d = (state_q == S_IDLE) ? (sim_tick ? ((fifo_level != '0) ? S_DRAIN : S_COMMIT) : S_IDLE) :
                  (state_q == S_DRAIN) ? ((n_drain_q == LW'(1)) ? S_COMMIT : S_DRAIN) : S_IDLE;
        n_drain_d = (state_q == S_IDLE && sim_tick) ? fifo_level :
                    (state_q == S_DRAIN) ? n_drain_q - LW'(1) : n_drain_q;
        shadow_d = shadow_q;
        for (int i = 0; i < NPARAM; i++)
            if (pop && rd_addr == ADDR_W'(i)) shadow_d[i] = rd_data;
        live_d = live_q;
        if (state_q == S_COMMIT) live_d = shadow_q;
        commit_d = state_q == S_COMMIT;
        ovf_d = (wr.wr_stb && full) || (ovf_q && !clr_err);
        bad_d = (pop && !addr_ok) || (bad_q && !clr_err);
        miss_d = (sim_tick && state_q != S_IDLE) || (miss_q && !clr_err);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPARAM; i++) begin
                shadow_q[i] <= RESET_VALS[i*PARAM_W +: PARAM_W];
                live_q[i] <= RESET_VALS[i*PARAM_W +: PARAM_W];
            end
            state_q <= S_IDLE;
            n_drain_q <= '0;
            commit_q <= 1'b0;
            ovf_q <= 1'b0;
            bad_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            live_q <= live_d;
            state_q <= state_d;
            n_drain_q <= n_drain_d;
            commit_q <= commit_d;
            ovf_q <= ovf_d;
            bad_q <= bad_d;
            miss_q <= miss_d;
        end
    end

    for (genvar i = 0; i < NPARAM; i++) begin : g_out
        assign params_out[i*PARAM_W +: PARAM_W] = live_q[i];
    end

    assign commit = commit_q;
    assign busy = state_q != S_IDLE;
    assign err_overflow = ovf_q;
    assign err_badaddr = bad_q;
    assign err_tickmiss = miss_q;
endmodule
